// File: rtl/d_bit_tx_if.sv
// Word handshake and serial line bundle for d_bit_tx.
// The slave view belongs to the transmitter. The master view belongs to whatever supplies the words.
interface d_bit_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             d_out;
  logic             d_valid;
  logic             d_last;
  logic             busy;

  modport master (
    output word_in, word_valid,
    input  word_ready, d_out, d_valid, d_last, busy
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, d_out, d_valid, d_last, busy
  );
endinterface

// File: rtl/d_bit_tx.sv
// Parallel-in/serial-out bit transmitter with a programmable idle gap between words.
// The bus interface WIDTH must match this module's WIDTH.
module d_bit_tx #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  d_bit_tx_if.slave   bus
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] sr;
  logic             d_out_r, d_valid_r, d_last_r;
  logic             word_ready_c, accept;

  // The shift register holds the bits still to be sent, next bit at the head.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  always_comb begin
    word_ready_c = 1'b0;
    unique case (state)
      ST_IDLE:  word_ready_c = 1'b1;
      ST_SHIFT: word_ready_c = (GAP == 0) && (bit_cnt == BIT_LAST);
      ST_GAP:   word_ready_c = (gap_cnt == GAP_LAST);
      default:  word_ready_c = 1'b0;
    endcase
    if (reset) word_ready_c = 1'b0;
  end

  assign accept = bus.word_valid && word_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sr        <= '0;
      d_out_r   <= 1'b0;
      d_valid_r <= 1'b0;
      d_last_r  <= 1'b0;
    end else if (accept) begin
      state     <= ST_SHIFT;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sr        <= advance(bus.word_in);
      d_out_r   <= first_bit(bus.word_in);
      d_valid_r <= 1'b1;
      d_last_r  <= 1'b0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            d_out_r   <= 1'b0;
            d_valid_r <= 1'b0;
            d_last_r  <= 1'b0;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            sr        <= advance(sr);
            d_out_r   <= first_bit(sr);
            d_valid_r <= 1'b1;
            d_last_r  <= (bit_cnt == BIT_PEN);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.word_ready = word_ready_c;
  assign bus.d_out      = d_out_r;
  assign bus.d_valid    = d_valid_r;
  assign bus.d_last     = d_last_r;
  assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_d_bit_tx.sv
// Self-checking bench: four d_bit_tx configurations share one stimulus stream.
// Each output is predicted from a cycles-since-accept model of the word frame.
module tb_d_bit_tx;
  localparam int NDUT = 4;
  localparam int BIG  = 1000;

  localparam int W_P [NDUT] = '{8, 8, 8, 2};
  localparam int G_P [NDUT] = '{1, 0, 2, 15};
  localparam int M_P [NDUT] = '{1, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic [31:0] win;

  always #5 clk = ~clk;

  d_bit_tx_if #(.WIDTH(8)) if0 ();
  d_bit_tx_if #(.WIDTH(8)) if1 ();
  d_bit_tx_if #(.WIDTH(8)) if2 ();
  d_bit_tx_if #(.WIDTH(2)) if3 ();

  assign if0.word_in = win[7:0];  assign if0.word_valid = vin;
  assign if1.word_in = win[7:0];  assign if1.word_valid = vin;
  assign if2.word_in = win[7:0];  assign if2.word_valid = vin;
  assign if3.word_in = win[1:0];  assign if3.word_valid = vin;

  d_bit_tx #(.WIDTH(8), .GAP(1),  .MSB_FIRST(1)) u0 (.clk(clk), .reset(rst), .bus(if0));
  d_bit_tx #(.WIDTH(8), .GAP(0),  .MSB_FIRST(1)) u1 (.clk(clk), .reset(rst), .bus(if1));
  d_bit_tx #(.WIDTH(8), .GAP(2),  .MSB_FIRST(0)) u2 (.clk(clk), .reset(rst), .bus(if2));
  d_bit_tx #(.WIDTH(2), .GAP(15), .MSB_FIRST(1)) u3 (.clk(clk), .reset(rst), .bus(if3));

  // Observed outputs packed as {word_ready, busy, d_valid, d_last, d_out}
  logic [4:0] act [NDUT];
  assign act[0] = {if0.word_ready, if0.busy, if0.d_valid, if0.d_last, if0.d_out};
  assign act[1] = {if1.word_ready, if1.busy, if1.d_valid, if1.d_last, if1.d_out};
  assign act[2] = {if2.word_ready, if2.busy, if2.d_valid, if2.d_last, if2.d_out};
  assign act[3] = {if3.word_ready, if3.busy, if3.d_valid, if3.d_last, if3.d_out};

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          started  = 1'b0;
  int          since [NDUT];
  logic [31:0] wd    [NDUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // A word occupies WIDTH bit cycles followed by GAP idle cycles after its accept edge.
  function automatic logic [4:0] expect_out(input int w, input int g, input int m,
                                            input int s, input logic [31:0] word,
                                            input logic r);
    logic rdy, bsy, dv, dl, dout;
    int   idx;
    rdy  = !r && (s >= w + g - 1);
    bsy  = (s < w + g);
    dv   = 1'b0;
    dl   = 1'b0;
    dout = 1'b0;
    if (s < w) begin
      idx  = (m != 0) ? (w - 1 - s) : s;
      dv   = 1'b1;
      dout = word[idx];
      dl   = (s == w - 1);
    end
    return {rdy, bsy, dv, dl, dout};
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] w);
    logic [4:0] e;
    bit         acc [NDUT];
    rst = r;
    vin = v;
    win = w;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      e = expect_out(W_P[i], G_P[i], M_P[i], since[i], wd[i], r);
      if (started) check($sformatf("dut%0d_cyc%0d", i, cyc), {27'd0, act[i]}, {27'd0, e});
      acc[i] = !r && v && e[4];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      if (r) since[i] = BIG;
      else if (acc[i]) begin
        since[i] = 0;
        wd[i]    = w;
      end else if (since[i] < BIG) since[i]++;
    end
    if (r) started = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      since[i] = BIG;
      wd[i]    = '0;
    end
    rst = 1'b1;
    vin = 1'b0;
    win = '0;
    #1;
    // Reset held two cycles with a word offered: it must be dropped.
    step(1'b1, 1'b1, 32'hA5);
    step(1'b1, 1'b1, 32'hA5);
    step(1'b0, 1'b1, 32'hA5);
    idle(20);
    // Back-to-back FF then 00 with valid held high.
    step(1'b0, 1'b1, 32'hFF);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h00);
    idle(20);
    step(1'b0, 1'b1, 32'h01);
    idle(20);
    // Reset pulse after the third bit of F0, then a fresh word.
    step(1'b0, 1'b1, 32'hF0);
    idle(2);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h81);
    idle(20);
    // Word changes every cycle while valid stays high.
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, $urandom);
    idle(20);
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), $urandom);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/d_bit_tx.md
# d_bit_tx

Parallel-in/serial-out bit transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock on `d_out`, which feeds the `d_in` pin of the team's flip-flop and capture blocks. It sits on the sending side of the single-bit data line that those blocks sample on every `posedge clk`. A programmable idle gap separates consecutive words. With GAP=0 it can stream words back-to-back.

## Interface
- `WIDTH`, 8 — word length in bits; legal range 2..32.
- `GAP`, 1 — number of `d_valid`-low cycles between consecutive words; legal range 0..15.
- `MSB_FIRST`, 1 — 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.

- `clk`  in  1  — single clock; all logic is on `posedge clk`.
- `reset`  in  1  — synchronous, active-high reset.
- `word_in`  in  WIDTH  — word to transmit; sampled only on accept.
- `word_valid`  in  1  — `word_in` is valid.
- `word_ready`  out  1  — the block can accept a word this cycle (combinational from state).
- `d_out`  out  WIDTH=1  — serial data bit (registered).
- `d_valid`  out  1  — `d_out` carries a word bit (registered).
- `d_last`  out  1  — current bit is the final bit of the word (registered).
- `busy`  out  1  — state is not IDLE.

## Operation
- Accept occurs on a `posedge clk` where `word_valid && word_ready && !reset`.
- States and transitions:
  - IDLE: `word_ready`=1. On accept, load the shift register, set bit_cnt=0, and go to SHIFT.
  - SHIFT: on each clock, advance the shift register and increment bit_cnt. When bit_cnt==WIDTH-1 the current bit is the last one:
    - with GAP>0, go to GAP with gap_cnt=0;
    - with GAP=0, an accept in this cycle reloads and stays in SHIFT; otherwise go to IDLE.
  - GAP: gap_cnt increments each clock. When gap_cnt==GAP-1, `word_ready`=1; an accept goes to SHIFT, otherwise go to IDLE.
- `word_ready` = IDLE, or (SHIFT && last bit && GAP==0), or (GAP && gap_cnt==GAP-1). It is forced to 0 while `reset`=1.
- When `d_valid`=0, `d_out` is 0 and `d_last` is 0.
- `word_in` and `word_valid` are ignored in every cycle except an accept cycle. Changes to `word_in` mid-word have no effect.
- Width rules:
  - bit_cnt is clog2(WIDTH) bits wide and gap_cnt is 4 bits wide.
  - Neither counter wraps: both are reset on every state entry.

## Timing
- Reset: on a `posedge clk` with `reset`=1, the block goes to IDLE with `d_out`=0, `d_valid`=0, `d_last`=0, `busy`=0, shift register 0, and both counters 0. `word_ready` rises in the first cycle after `reset` deasserts.
- Reset mid-word aborts the word. No further bits of it appear, and `d_valid`=0 from the next edge onward.
- Reset together with an accept: reset wins and the word is dropped.
- Latency: for an accept at edge k, the first bit is on `d_out` with `d_valid`=1 immediately after edge k. Bit i appears after edge k+i. `d_last`=1 only after edge k+WIDTH-1.
- After the last bit, `d_valid` is low for exactly GAP cycles when the next word is presented in time. If it is presented late, `d_valid` stays low until the next accept edge.
- Throughput: one word per WIDTH+GAP cycles. With GAP=0, `d_valid` stays high continuously across words.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `word_valid`=1 → all outputs stay 0 and `word_ready`=0; `word_ready`=1 in the first cycle after release.
- Single word (WIDTH=8, GAP=1, MSB_FIRST=1), 8'hA5 → `d_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `d_last` only on the 8th; then exactly 1 `d_valid`-low cycle before the next word's first bit.
- Back-to-back (GAP=0), 8'hFF then 8'h00 with `word_valid` held high → 16 contiguous `d_valid` cycles (eight 1s, then eight 0s); `d_last` on cycles 8 and 16.
- LSB-first (MSB_FIRST=0), 8'h01 → `d_out` = 1 followed by seven 0s.
- Reset mid-word: pulse reset after the 3rd bit of 8'hF0 → `d_valid`=0 on the next cycle and no further bits; a subsequent word 8'h81 then transmits as 1,0,0,0,0,0,0,1.
- Input stability: keep `word_valid`=1 and change `word_in` every cycle while `busy` → transmitted bits equal `word_in` as sampled at the accept edge only.
